// File: rtl/bcd_stopwatch.sv
// Debounced start/pause/clear keys driving an N-digit up/down BCD counter with a wrap pulse
// and registered active-low 7-segment outputs (gfedcba per digit).
module bcd_stopwatch #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned TICK_DIV       = 50_000_000,
  parameter int unsigned DEBOUNCE       = 1_000_000,
  parameter int unsigned KEY_ACTIVE_LOW = 1,
  parameter int unsigned BLANK_LZ       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                KEY0,
  input  logic                KEY1,
  input  logic                KEY2,
  input  logic                dir,
  output logic [DIGITS*7-1:0] HEX,
  output logic                running,
  output logic                wrap,
  output logic [DIGITS*4-1:0] count
);

  localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned   DW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DbMax    = DW'(DEBOUNCE - 1);
  // Pin level of a released key; XOR with it normalises to pressed = 1.
  localparam logic [2:0]    KeyIdle  = (KEY_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [DIGITS*7-1:0] hex_of(input logic [DIGITS*4-1:0] c);
    logic [DIGITS*7-1:0] h;
    logic                upper_zero;
    h          = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (c[4*i +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (i != 0) && upper_zero) h[7*i +: 7] = 7'b1111111;
      else                                            h[7*i +: 7] = seg7(c[4*i +: 4]);
    end
    return h;
  endfunction

  // Key path: synchroniser, debouncer, rising-edge event.
  logic [2:0]    sync1_q, sync2_q, pressed, level_q, level_prev_q, key_ev;
  logic [DW-1:0] db_cnt_q [3];

  assign pressed = sync2_q ^ KeyIdle;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= KeyIdle;
      sync2_q      <= KeyIdle;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q      <= {KEY2, KEY1, KEY0};
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      for (int k = 0; k < 3; k++) begin
        if (pressed[k] == level_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DbMax) begin
          level_q[k]  <= pressed[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DW'(1);
        end
      end
    end
  end

  assign key_ev = level_q & ~level_prev_q;

  state_e              state_q;
  logic [PW-1:0]       presc_q;
  logic [DIGITS*4-1:0] count_q, count_nxt;
  logic [DIGITS*7-1:0] hex_q;
  logic                running_q, wrap_q, tick, carry;
  logic [3:0]          digit;

  assign tick = (state_q == StRun) && (presc_q == PrescMax);

  // Ripple increment/decrement; carry out of the top digit marks a wrap.
  always_comb begin
    count_nxt = count_q;
    carry     = 1'b1;
    digit     = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (!dir) begin
          if (digit >= 4'd9) digit = 4'd0;
          else begin
            digit = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) digit = 4'd9;
          else begin
            digit = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      count_nxt[4*i +: 4] = digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
      presc_q   <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      hex_q     <= hex_of('0);
    end else begin
      wrap_q <= 1'b0;
      hex_q  <= hex_of(count_q);
      if (state_q == StRun) presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        count_q <= count_nxt;
        wrap_q  <= carry;
      end
      // Only the highest-priority event acts, even when it is ignored in this state.
      if (key_ev[2]) begin
        state_q   <= StIdle;
        running_q <= 1'b0;
        presc_q   <= '0;
        count_q   <= '0;
        wrap_q    <= 1'b0;
      end else if (key_ev[1]) begin
        if (state_q == StRun) begin
          state_q   <= StPause;
          running_q <= 1'b0;
        end
      end else if (key_ev[0]) begin
        if (state_q == StIdle) begin
          state_q   <= StRun;
          running_q <= 1'b1;
          presc_q   <= '0;
        end else if (state_q == StPause) begin
          state_q   <= StRun;
          running_q <= 1'b1;
        end
      end
    end
  end

  assign HEX     = hex_q;
  assign running = running_q;
  assign wrap    = wrap_q;
  assign count   = count_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: a decimal model feeds a scoreboard of expected count changes,
// plus directed sequences for key latency, pause/resume, wrap, priority, blanking and reset.
module tb_bcd_stopwatch;

  localparam int TICK_DIV = 4;
  localparam int DEBOUNCE = 3;
  // Prescaler value frozen by a pause whose key was pressed in the cycle a count landed.
  localparam int HELD = (2 + DEBOUNCE) % TICK_DIV + 1;
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct packed {
    logic [15:0] cnt;
    logic        w;
  } exp_t;

  typedef struct {
    logic        d;
    int          steps;
    logic [15:0] last;
  } seg_t;

  logic        clk = 1'b0, rst = 1'b1, dir = 1'b0;
  logic        key0 = 1'b0, key1 = 1'b0, key2 = 1'b0;
  logic [27:0] hex, hex_lz;
  logic [15:0] count, count_lz;
  logic        running, wrap, running_lz, wrap_lz;

  int          n_checks = 0, n_fail = 0, cyc = 0, model = 0;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic        sb_on = 1'b0, hex_due = 1'b0;
  logic [15:0] prev_cnt = '0, hex_cnt = '0;
  seg_t        segs [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_stopwatch #(.DIGITS(4), .TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE), .KEY_ACTIVE_LOW(0),
                  .BLANK_LZ(0)) dut (
    .clk(clk), .rst(rst), .KEY0(key0), .KEY1(key1), .KEY2(key2), .dir(dir),
    .HEX(hex), .running(running), .wrap(wrap), .count(count)
  );

  bcd_stopwatch #(.DIGITS(4), .TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE), .KEY_ACTIVE_LOW(0),
                  .BLANK_LZ(1)) dut_lz (
    .clk(clk), .rst(rst), .KEY0(key0), .KEY1(key1), .KEY2(key2), .dir(dir),
    .HEX(hex_lz), .running(running_lz), .wrap(wrap_lz), .count(count_lz)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int          r;
    r = v;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic [27:0] hex_model(input logic [15:0] c, input bit lz);
    logic [27:0] h;
    bit          hi_zero;
    h       = '0;
    hi_zero = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      hi_zero = hi_zero && (c[4*i +: 4] == 4'd0);
      if (lz && i > 0 && hi_zero) h[7*i +: 7] = 7'h7f;
      else                        h[7*i +: 7] = SEG[c[4*i +: 4]];
    end
    return h;
  endfunction

  task automatic push_steps(input logic d, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (!d) begin
        e.w   = (model == 9999);
        model = e.w ? 0 : model + 1;
      end else begin
        e.w   = (model == 0);
        model = e.w ? 9999 : model - 1;
      end
      e.cnt = to_bcd(model);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_clear();
    exp_t e;
    model = 0;
    e.cnt = '0;
    e.w   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_count(input logic [15:0] tgt, input int bound, input string nm);
    int n;
    n = 0;
    while (count !== tgt && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(count), 32'(tgt));
  endtask

  // Cycles from running rising to the next count change.
  task automatic wait_gap(input string nm, input int req_gap);
    int          n, t0;
    logic [15:0] c0;
    n = 0;
    while (running !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    c0 = count;
    n  = 0;
    while (count === c0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(cyc - t0), 32'(req_gap));
  endtask

  // Scoreboard: every count change pops one expected entry; HEX checked the cycle after.
  always @(negedge clk) begin
    if (hex_due) begin
      chk("hex", 32'(hex), 32'(hex_model(hex_cnt, 1'b0)));
      chk("hex_lz", 32'(hex_lz), 32'(hex_model(hex_cnt, 1'b1)));
      hex_due = 1'b0;
    end
    if (sb_on && !rst) begin
      if (count !== prev_cnt) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_change", 32'(count), 32'(prev_cnt));
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_count", 32'(count), 32'(mon_e.cnt));
          chk("sb_wrap", 32'(wrap), 32'(mon_e.w));
          hex_cnt = mon_e.cnt;
          hex_due = 1'b1;
        end
      end else begin
        chk("wrap_idle", 32'(wrap), 32'd0);
      end
    end
    prev_cnt = count;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    segs[0] = '{1'b1, 2, 16'h9998};
    segs[1] = '{1'b0, 3, 16'h0001};
    segs[2] = '{1'b0, 40, 16'h0041};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_hex", 32'(hex), 32'({4{7'h40}}));
    chk("rst_hex_lz", 32'(hex_lz), 32'({7'h7f, 7'h7f, 7'h7f, 7'h40}));
    sb_on = 1'b1;

    // Two-cycle glitch must be rejected.
    key0 = 1'b1;
    repeat (2) @(negedge clk);
    key0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_ignored", 32'(running), 32'd0);

    // Clean press: running in cycle 6, first count 4 cycles later.
    push_steps(1'b0, 3);
    key0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) chk("start_lat_pre", 32'(running), 32'd0);
      if (c == 6) begin
        chk("start_lat", 32'(running), 32'd1);
        key0 = 1'b0;
      end
      if (c == 9) chk("first_tick_pre", 32'(count), 32'd0);
      if (c == 10) chk("first_tick", 32'(count), 32'h0001);
    end

    // Pause so that it lands while 0003 is shown, then hold and resume.
    wait_count(16'h0002, 20, "reach_0002");
    key1 = 1'b1;
    repeat (6) @(negedge clk);
    key1 = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("pause_hold", 32'(count), 32'h0003);
      chk("pause_running", 32'(running), 32'd0);
    end
    push_steps(1'b0, 1);
    key0 = 1'b1;
    wait_gap("resume_gap", TICK_DIV - HELD);
    key0 = 1'b0;

    // Pause+clear together in RUN: clear wins; one tick lands during key latency.
    push_steps(1'b0, 1);
    push_clear();
    key1 = 1'b1;
    key2 = 1'b1;
    repeat (6) @(negedge clk);
    key1 = 1'b0;
    key2 = 1'b0;
    wait_count(16'h0000, 20, "prio_clear");
    chk("prio_idle", 32'(running), 32'd0);

    // Down wrap from idle, up wrap, then count on to 0041.
    for (int s = 0; s < 3; s++) begin
      dir = segs[s].d;
      push_steps(segs[s].d, segs[s].steps);
      if (s == 0) begin
        key0 = 1'b1;
        wait_gap("idle_start_gap", TICK_DIV);
        key0 = 1'b0;
      end
      wait_count(segs[s].last, segs[s].steps * TICK_DIV + 20, "seg_reach");
      chk("seg_end", 32'(count), 32'(segs[s].last));
    end

    // Pause with 0042 on display and check leading-zero blanking.
    push_steps(1'b0, 1);
    key1 = 1'b1;
    repeat (6) @(negedge clk);
    key1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("blank_count", 32'(count), 32'h0042);
    chk("blank_running", 32'(running), 32'd0);
    chk("hex_0042", 32'(hex), 32'({7'h40, 7'h40, 7'h19, 7'h24}));
    chk("hex_lz_0042", 32'(hex_lz), 32'({7'h7f, 7'h7f, 7'h19, 7'h24}));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a debounce: no event may follow.
    sb_on = 1'b0;
    key0  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    key0 = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_lz", 32'({running_lz, wrap_lz, count_lz}), 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("midrst_no_event", 32'(running), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Parametrised N-digit BCD stopwatch/counter with start, pause and clear keys, up/down counting, wrap detection and a registered 7-segment output per digit. It replaces the fixed 3-key, 4-digit top-level counter. It sits between the board push-buttons and the HEX displays, and can be instantiated standalone in `main` or any future top level.

## Interface
- `DIGITS`, 4: number of BCD digits and 7-segment outputs (1..8).
- `TICK_DIV`, 50_000_000: clocks per count tick (≥2).
- `DEBOUNCE`, 1_000_000: consecutive stable clocks required to accept a key level (≥1).
- `KEY_ACTIVE_LOW`, 1: 1 means a pressed key reads 0 on the pin.
- `BLANK_LZ`, 0: 1 blanks leading zero digits; digit 0 is never blanked.

Ports:
- `clk` input 1: single system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `KEY0` input 1: start/resume key (raw, asynchronous).
- `KEY1` input 1: pause key (raw, asynchronous).
- `KEY2` input 1: clear key (raw, asynchronous).
- `dir` input 1: 0 counts up, 1 counts down; sampled on each tick.
- `HEX` output DIGITS*7: segments for digit i at [7i+6:7i], order gfedcba, active-low.
- `running` output 1: high in state RUN.
- `wrap` output 1: one-cycle pulse on counter wrap-around.
- `count` output DIGITS*4: current BCD value; digit i at [4i+3:4i].

## Operation
- Key path per key:
  - 2-FF synchroniser.
  - Polarity normalise per `KEY_ACTIVE_LOW`, giving pressed = 1.
  - Debouncer: the level is accepted after `DEBOUNCE` consecutive equal samples that differ from the current accepted level.
  - Rising edge of the accepted level produces a one-cycle event: `ev_start`, `ev_pause` or `ev_clear`.
- FSM states:
  - IDLE: count = 0, prescaler = 0.
  - RUN.
  - PAUSE.
- FSM transitions:
  - `ev_clear` from any state goes to IDLE and zeroes count and prescaler.
  - `ev_start` in IDLE goes to RUN with prescaler restarted at 0.
  - `ev_start` in PAUSE goes to RUN with the prescaler resumed from its held value.
  - `ev_pause` in RUN goes to PAUSE; prescaler and count are held.
  - All other events are ignored. This includes `ev_start` in RUN and `ev_pause` in IDLE or PAUSE.
- Simultaneous events are resolved by priority clear > pause > start. Only the highest-priority event acts.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - A tick is issued when the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
- BCD counter, on each tick:
  - Up: increment with decimal carry. 10^DIGITS−1 wraps to 0 and pulses `wrap`.
  - Down: decrement with decimal borrow. 0 wraps to all-9s and pulses `wrap`.
  - Every digit always stays in the range 0..9.
- Decoder:
  - Digits 0..9 use the standard pattern; for example, 0 = 7'b1000000 and 8 = 7'b0000000.
  - Blank = 7'b1111111.
  - With `BLANK_LZ`=1, a digit above index 0 is blanked when it and all higher digits are 0.
- `rst` overrides everything. It sets the FSM to IDLE and clears count, prescaler, synchronisers, debouncers and edge registers. Accepted key level resets to released. This applies even mid-debounce or mid-tick.

## Timing
- Reset values:
  - `HEX` = every digit shows "0" (7'b1000000 each). With `BLANK_LZ`=1, the upper digits are 7'b1111111.
  - `running` = 0, `wrap` = 0, `count` = 0.
- Key latency: a raw key change stable from cycle 0 gives the event in cycle 2+DEBOUNCE. The FSM state and `running` update one cycle later.
- Count latency:
  - `count` updates on the clock edge after the tick cycle.
  - `wrap` is high in that same cycle, for exactly one cycle.
  - `HEX` is registered and lags `count` by 1 cycle.
- Tick spacing in uninterrupted RUN is exactly `TICK_DIV` cycles. The first tick after start from IDLE occurs `TICK_DIV` cycles after entering RUN.
- A pause in the same cycle as a tick: the tick is applied and the FSM still goes to PAUSE.
- A clear in the same cycle as a tick: clear wins, so count = 0 and `wrap` = 0.
- A `dir` change takes effect on the next tick. It never alters an in-progress value.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=4, DEBOUNCE=3, KEY_ACTIVE_LOW=0.

- Reset: hold `rst` 2 cycles, then release. Required: `count`=0, `running`=0, `wrap`=0, every `HEX` digit = 7'b1000000.
- Debounce: pulse KEY0 high for 2 cycles, then low. Required: no state change. Hold KEY0 high for 6 cycles. Required: `running`=1 in cycle 6 after the rising edge, and `count`=0001 after 4 more cycles.
- Pause/resume: start, run until `count`=0003, pulse KEY1. Required: `count` holds 0003 for 50 cycles. Then KEY0. Required: 0004 arrives exactly (remaining prescaler) cycles after RUN resumes.
- Up wrap: force `count` to 9998 via ticks, `dir`=0. Required: 9999, then 0000 with `wrap` high for one cycle.
- Down wrap: from 0000 with `dir`=1 and run. Required: 9999 with a `wrap` pulse, then 9998.
- Priority and blanking: press KEY1 and KEY2 together while in RUN. Required: IDLE with `count`=0. With `BLANK_LZ`=1 and `count`=0042, `HEX` digits 3..0 = blank, blank, "4", "2". Assert `rst` mid-debounce. Required: no event is produced afterwards.
